// File: rtl/alu_pkg.sv
// Shared ALU constants and the result flag bundle used by the adder stages.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned CLA_GROUP = 4;

  typedef struct packed {
    logic neg;
    logic zero;
    logic cout;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/cla_sum_stage_if.sv
// G/P/C input handshake and registered sum/flag output bus of cla_sum_stage.
interface cla_sum_stage_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned TAG_W = 4
);

  localparam int unsigned NGROUP = WIDTH / CLA_GROUP;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_g;
  logic [WIDTH-1:0]  in_p;
  logic [NGROUP:0]   in_c;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_sum;
  logic [TAG_W-1:0]  out_tag;
  logic              out_cout;
  logic              out_ovf;
  logic              out_zero;
  logic              out_neg;

  modport master (
    output in_valid, in_g, in_p, in_c, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_tag,
    input  out_cout, out_ovf, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_g, in_p, in_c, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_tag,
    output out_cout, out_ovf, out_zero, out_neg
  );

endinterface

// File: rtl/cla_group_sum.sv
// 4-bit in-group carry ripple and sum from per-bit generate/propagate and group carry-in.
module cla_group_sum
  import alu_pkg::*;
(
  input  logic [CLA_GROUP-1:0] g,
  input  logic [CLA_GROUP-1:0] p,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] sum_c,
  output logic                 cout_c
);

  logic [CLA_GROUP:0] c;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(CLA_GROUP); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum_c  = p ^ c[CLA_GROUP-1:0];
  assign cout_c = c[CLA_GROUP];

endmodule

// File: rtl/cla_sum_stage.sv
// Registered CLA sum-and-flags stage with valid/ready handshake and 1-cycle latency.
// Optional skid entry decoupling in_ready from out_ready: define CLA_SUM_SKID_EN.
module cla_sum_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  cla_sum_stage_if.slave    bus
);

  localparam int unsigned NGROUP = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0]  sum_c;
  logic [NGROUP-1:0] grp_cout_c;
  alu_flags_t        flags_c;
  logic              unused_ok;

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_sum_q;
  logic [TAG_W-1:0]  out_tag_q;
  alu_flags_t        out_flags_q;

  logic              accept;
  logic              consume;

  for (genvar k = 0; k < int'(NGROUP); k++) begin : g_grp
    cla_group_sum u_grp (
      .g      (bus.in_g[k*CLA_GROUP +: CLA_GROUP]),
      .p      (bus.in_p[k*CLA_GROUP +: CLA_GROUP]),
      .cin    (bus.in_c[k]),
      .sum_c  (sum_c[k*CLA_GROUP +: CLA_GROUP]),
      .cout_c (grp_cout_c[k])
    );
  end

  // Only the top group's ripple matters (for ovf); the others are implied by in_c.
  assign unused_ok = ^grp_cout_c;

  // c[WIDTH-1] is recovered from the top sum bit: sum = p ^ c.
  always_comb begin
    flags_c      = '0;
    flags_c.neg  = sum_c[WIDTH-1];
    flags_c.zero = ~|sum_c;
    flags_c.cout = bus.in_c[NGROUP];
    flags_c.ovf  = (sum_c[WIDTH-1] ^ bus.in_p[WIDTH-1]) ^ grp_cout_c[NGROUP-1];
  end

  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = out_valid_q & bus.out_ready;

`ifdef CLA_SUM_SKID_EN
  logic              skid_valid_q;
  logic [WIDTH-1:0]  skid_sum_q;
  logic [TAG_W-1:0]  skid_tag_q;
  alu_flags_t        skid_flags_q;

  assign bus.in_ready = ~skid_valid_q & ~rst;

  // Output register refills from skid first; a stalled accept parks in skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_tag_q    <= '0;
      out_flags_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_sum_q   <= '0;
      skid_tag_q   <= '0;
      skid_flags_q <= '0;
    end else if (!out_valid_q || consume) begin
      if (skid_valid_q) begin
        out_sum_q    <= skid_sum_q;
        out_tag_q    <= skid_tag_q;
        out_flags_q  <= skid_flags_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q  <= 1'b1;
        out_sum_q    <= sum_c;
        out_tag_q    <= bus.in_tag;
        out_flags_q  <= flags_c;
      end else begin
        out_valid_q  <= 1'b0;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_sum_q   <= sum_c;
      skid_tag_q   <= bus.in_tag;
      skid_flags_q <= flags_c;
    end
  end
`else
  assign bus.in_ready = (~out_valid_q | bus.out_ready) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_tag_q   <= '0;
      out_flags_q <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= sum_c;
      out_tag_q   <= bus.in_tag;
      out_flags_q <= flags_c;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_neg   = out_flags_q.neg;
  assign bus.out_zero  = out_flags_q.zero;
  assign bus.out_cout  = out_flags_q.cout;
  assign bus.out_ovf   = out_flags_q.ovf;

endmodule

// File: tb/tb_cla_sum_stage.sv
// Directed and streaming checks of cla_sum_stage driven from A/B/Cin through a G/P/C model.
module tb_cla_sum_stage;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned NG    = WIDTH / CLA_GROUP;
`ifdef CLA_SUM_SKID_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cla_sum_stage_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  cla_sum_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Carry into bit 4k of A+B+Cin, taken from a masked wide addition.
  function automatic logic [NG:0] grp_carries(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin);
    logic [63:0] m;
    logic [63:0] s;
    logic [NG:0] c;
    c = '0;
    for (int k = 0; k <= int'(NG); k++) begin
      m    = (64'd1 << (4 * k)) - 64'd1;
      s    = (64'(a) & m) + (64'(b) & m) + 64'(cin);
      c[k] = s[4 * k];
    end
    return c;
  endfunction

  function automatic exp_t ref_of(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic [3:0] tag);
    exp_t        e;
    logic [32:0] s;
    s       = 33'(a) + 33'(b) + 33'(cin);
    e.sum   = s[31:0];
    e.flags = {s[31], s[31:0] == 32'd0, s[32], (a[31] == b[31]) && (s[31] != a[31])};
    e.tag   = tag;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [3:0] tag);
    bus.in_valid = v;
    bus.in_g     = a & b;
    bus.in_p     = a ^ b;
    bus.in_c     = grp_carries(a, b, cin);
    bus.in_tag   = tag;
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.out_neg, bus.out_zero, bus.out_cout, bus.out_ovf};
  endfunction

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [3:0] tag,
                          input logic [31:0] exp_sum, input logic [3:0] exp_flags);
    drive(1'b1, a, b, cin, tag);
    @(posedge clk);
    #1;
    drive(1'b0, a, b, cin, tag);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_sum"},   64'(bus.out_sum),   64'(exp_sum));
    chk({name, "_flags"}, 64'(flags_now()),   64'(exp_flags));
    chk({name, "_tag"},   64'(bus.out_tag),   64'(tag));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    int          nacc;
    int          nrcv;
    logic        acc;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [3:0]  tg;
    logic [3:0]  got[$];
    exp_t        e;
    exp_t        expq[$];

    // Reset state
    bus.out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_sum",   64'(bus.out_sum),   64'd0);
    chk("rst_out_tag",   64'(bus.out_tag),   64'd0);
    chk("rst_flags",     64'(flags_now()),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed arithmetic cases; flags are {neg, zero, cout, ovf}
    directed("ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'd5, 32'h8000_0000, 4'b1001);
    directed("czero",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd6, 32'h0000_0000, 4'b0110);
    directed("sub_p",  32'd5, ~32'd3, 1'b1, 4'd7, 32'h0000_0002, 4'b0010);
    directed("sub_n",  32'd3, ~32'd5, 1'b1, 4'd8, 32'hFFFF_FFFE, 4'b1000);
    @(posedge clk);
    #1;
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    // Back-pressure: three stalled cycles offering tags 1, 2, 3
    bus.out_ready = 1'b0;
    idx = 0;
    for (int n = 0; n < 3; n++) begin
      if (idx < 3) drive(1'b1, 32'(idx + 1), 32'd1, 1'b0, 4'(idx + 1));
      else         drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepts",    64'(idx),           64'(DEPTH));
    chk("bp_in_ready",   64'(bus.in_ready),  64'd0);
    chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_hold_tag",   64'(bus.out_tag),   64'd1);
    chk("bp_hold_sum",   64'(bus.out_sum),   64'd2);

    bus.out_ready = 1'b1;
    for (int n = 0; n < 20 && got.size() < 3; n++) begin
      if (idx < 3) drive(1'b1, 32'(idx + 1), 32'd1, 1'b0, 4'(idx + 1));
      else         drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_tag);
      if (acc) idx++;
      @(posedge clk);
      #1;
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < got.size(); i++) chk("bp_order", 64'(got[i]), 64'(i + 1));
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // Full-rate streaming of random operands
    nacc = 0;
    nrcv = 0;
    a = 32'd0;
    b = 32'd0;
    cin = 1'b0;
    tg = 4'd0;
    for (int n = 0; n < 101; n++) begin
      if (n < 100) begin
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        tg  = 4'(n);
        drive(1'b1, a, b, cin, tg);
      end else begin
        drive(1'b0, a, b, cin, tg);
      end
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        nrcv++;
        if (expq.size() == 0) begin
          chk("stream_spurious", 64'(bus.out_valid), 64'd0);
        end else begin
          e = expq.pop_front();
          chk("stream_sum",   64'(bus.out_sum), 64'(e.sum));
          chk("stream_flags", 64'(flags_now()), 64'(e.flags));
          chk("stream_tag",   64'(bus.out_tag), 64'(e.tag));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(ref_of(a, b, cin, tg));
        nacc++;
      end
      @(posedge clk);
      #1;
    end
    chk("stream_acc", 64'(nacc), 64'd100);
    chk("stream_rcv", 64'(nrcv), 64'd100);

    // Reset with the buffer full
    bus.out_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 32'(10 + n), 32'd0, 1'b0, 4'(9 + n));
      @(posedge clk);
      #1;
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    chk("rm_full_valid", 64'(bus.out_valid), 64'd1);
    chk("rm_full_ready", 64'(bus.in_ready),  64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rm_rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rm_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rm_out_sum",   64'(bus.out_sum),   64'd0);
    chk("rm_out_tag",   64'(bus.out_tag),   64'd0);
    chk("rm_flags",     64'(flags_now()),   64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rm_post_in_ready", 64'(bus.in_ready), 64'd1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rm_no_stale", 64'(bus.out_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
